// File: rtl/pim_dma_master_pkg.sv
// Shared definitions for the PIM DMA master: op codes, status word constants and FSM states.
package pim_dma_master_pkg;

  localparam logic [31:0] STATUS_ADDR_DEFAULT = 32'h0000_0FFC;
  localparam logic [7:0]  STATUS_MAGIC        = 8'hD0;

  localparam logic [1:0] OP_COPY = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_STAT,
    S_DONE
  } state_e;

endpackage

// File: rtl/pim_dma_master_word_op.sv
// Combinational word transform applied between read and write; the reserved op behaves as copy.
module pim_dma_master_word_op
  import pim_dma_master_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [31:0] operand,
  input  logic [31:0] rdata,
  output logic [31:0] wdata
);

  always_comb begin
    wdata = rdata;
    case (op)
      OP_ADD:  wdata = rdata + operand;
      OP_XOR:  wdata = rdata ^ operand;
      default: wdata = rdata;
    endcase
  end

endmodule

// File: rtl/pim_dma_master.sv
// Second bus master: reads len words from src, transforms them, writes them to dst, then posts a status word.
//   state  | meaning
//   IDLE   | waiting for start
//   RD     | read strobe for current source word
//   WR     | write transformed word to destination
//   STAT   | write completion word to status location
//   DONE   | one-cycle done pulse
module pim_dma_master
  import pim_dma_master_pkg::*;
#(
  parameter logic [31:0] STATUS_ADDR = STATUS_ADDR_DEFAULT,
  parameter int          LEN_W       = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  input  logic [1:0]       op,
  input  logic [31:0]      operand,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [31:0]      mem_addr,
  output logic             mem_rstrb,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_wmask,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_rbusy,
  input  logic             mem_wbusy
);

  state_e           state, state_nx;
  logic [31:0]      src_ptr, dst_ptr, operand_q, op_wdata, status_word;
  logic [1:0]       op_q;
  logic [LEN_W-1:0] len_q, cnt;
  logic             err_nx, wrote_q, last_word;

  pim_dma_master_word_op u_word_op (
    .op      (op_q),
    .operand (operand_q),
    .rdata   (mem_rdata),
    .wdata   (op_wdata)
  );

  assign last_word   = (cnt + LEN_W'(1)) == len_q;
  assign status_word = {STATUS_MAGIC, {(23-LEN_W){1'b0}}, err_nx, cnt};

  // Protocol checks: read must be acknowledged in WR, a write must be acknowledged the cycle after it.
  always_comb begin
    err_nx = err;
    case (state)
      S_IDLE:      if (start) err_nx = 1'b0;
      S_WR:        if (!mem_rbusy) err_nx = 1'b1;
      S_RD, S_STAT: if (wrote_q && !mem_wbusy) err_nx = 1'b1;
      default:     err_nx = err;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    busy      = 1'b0;
    done      = 1'b0;
    mem_addr  = 32'h0;
    mem_rstrb = 1'b0;
    mem_wdata = 32'h0;
    mem_wmask = 4'h0;
    case (state)
      S_IDLE: if (start) state_nx = (len == '0) ? S_STAT : S_RD;
      S_RD: begin
        busy      = 1'b1;
        mem_addr  = src_ptr;
        mem_rstrb = 1'b1;
        state_nx  = S_WR;
      end
      S_WR: begin
        busy      = 1'b1;
        mem_addr  = dst_ptr;
        mem_wmask = 4'hF;
        mem_wdata = op_wdata;
        state_nx  = last_word ? S_STAT : S_RD;
      end
      S_STAT: begin
        busy      = 1'b1;
        mem_addr  = {STATUS_ADDR[31:2], 2'b00};
        mem_wmask = 4'hF;
        mem_wdata = status_word;
        state_nx  = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      src_ptr   <= 32'h0;
      dst_ptr   <= 32'h0;
      operand_q <= 32'h0;
      op_q      <= 2'b00;
      len_q     <= '0;
      cnt       <= '0;
      err       <= 1'b0;
      wrote_q   <= 1'b0;
    end else begin
      err     <= err_nx;
      wrote_q <= (state == S_WR) || (state == S_STAT);
      if (state == S_IDLE && start) begin
        src_ptr   <= {src_addr[31:2], 2'b00};
        dst_ptr   <= {dst_addr[31:2], 2'b00};
        operand_q <= operand;
        op_q      <= op;
        len_q     <= len;
        cnt       <= '0;
      end else if (state == S_WR) begin
        src_ptr <= src_ptr + 32'd4;
        dst_ptr <= dst_ptr + 32'd4;
        cnt     <= cnt + LEN_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pim_dma_master.sv
// Randomized bench for pim_dma_master with a fixed-latency memory model and a word-level reference model.
module tb_pim_dma_master;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] src_addr, dst_addr, operand;
  logic [9:0]  len;
  logic [1:0]  op;
  logic        busy, done, err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rstrb;
  logic [3:0]  mem_wmask;
  logic        mem_rbusy = 1'b0;
  logic        mem_wbusy = 1'b0;

  always #5 clk = ~clk;

  pim_dma_master dut (
    .clk(clk), .reset(reset), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .len(len), .op(op), .operand(operand), .busy(busy), .done(done), .err(err),
    .mem_addr(mem_addr), .mem_rstrb(mem_rstrb), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rdata(mem_rdata), .mem_rbusy(mem_rbusy), .mem_wbusy(mem_wbusy)
  );

  // Memory model: 4 KB, read data one cycle after strobe, busy flags follow the previous cycle's access.
  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic [31:0] rdata_q = 32'h0;
  int          rd_cnt = 0, wr_cnt = 0, done_cnt = 0;
  int          withhold_at = -1;
  bit          both_strobes = 1'b0;
  bit          fill_req = 1'b0;
  bit          bd_we = 1'b0;
  int          bd_idx = 0;
  logic [31:0] bd_data = 32'h0;

  assign mem_rdata = rdata_q;

  always @(posedge clk) begin
    if (fill_req)
      for (int i = 0; i < 1024; i++) mem[i] <= $urandom;
    if (bd_we) mem[bd_idx] <= bd_data;
    if (mem_rstrb) begin
      rdata_q <= mem[mem_addr[11:2]];
      rd_cnt  <= rd_cnt + 1;
    end
    if (mem_wmask != 4'h0) begin
      mem[mem_addr[11:2]] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    mem_rbusy <= mem_rstrb && (rd_cnt != withhold_at);
    mem_wbusy <= (mem_wmask != 4'h0);
    if (done) done_cnt <= done_cnt + 1;
    if (mem_rstrb && mem_wmask != 4'h0) both_strobes <= 1'b1;
  end

  int tests = 0, fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word_f(input logic [1:0] o, input logic [31:0] k, input logic [31:0] r);
    if (o == 2'b01) return r + k;
    if (o == 2'b10) return r ^ k;
    return r;
  endfunction

  task automatic fill();
    @(negedge clk); fill_req = 1'b1;
    @(negedge clk); fill_req = 1'b0;
  endtask

  task automatic poke(input int idx, input logic [31:0] data);
    @(negedge clk); bd_we = 1'b1; bd_idx = idx; bd_data = data;
    @(negedge clk); bd_we = 1'b0;
  endtask

  task automatic snapshot();
    for (int i = 0; i < 1024; i++) ref_mem[i] = mem[i];
  endtask

  task automatic apply_model(input logic [31:0] s, input logic [31:0] d, input int n,
                             input logic [1:0] o, input logic [31:0] k);
    for (int i = 0; i < n; i++)
      ref_mem[((d >> 2) + i) & 1023] = word_f(o, k, ref_mem[((s >> 2) + i) & 1023]);
  endtask

  task automatic compare_mem(input string tag);
    int bad = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad++;
    check(tag, bad, 0);
  endtask

  task automatic drive_start(input logic [31:0] s, input logic [31:0] d, input int n,
                             input logic [1:0] o, input logic [31:0] k);
    @(negedge clk);
    start = 1'b1; src_addr = s | 32'($urandom_range(0, 3)); dst_addr = d | 32'($urandom_range(0, 3));
    len = 10'(n); op = o; operand = k;
    @(negedge clk);
    start = 1'b0; src_addr = $urandom; dst_addr = $urandom; len = 10'($urandom);
    op = 2'($urandom); operand = $urandom;
  endtask

  // Runs one transfer; wh = index of read whose ack is withheld (-1 none), kick_at = cycle of a stray start.
  task automatic xfer(input string nm, input logic [31:0] s, input logic [31:0] d, input int n,
                      input logic [1:0] o, input logic [31:0] k, input int wh, input int kick_at);
    int rd0, wr0, dn0, cyc;
    bit exp_err;
    snapshot();
    apply_model(s, d, n, o, k);
    exp_err = (wh >= 0) && (wh < n);
    ref_mem[1023] = 32'hD000_0000 | (32'(exp_err) << 10) | 32'(n);
    rd0 = rd_cnt; wr0 = wr_cnt; dn0 = done_cnt;
    withhold_at = (wh >= 0) ? rd0 + wh : -1;
    drive_start(s, d, n, o, k);
    cyc = 1;
    check({nm, "_busy1"}, busy, 1'b1);
    check({nm, "_errclr"}, err, 1'b0);
    while (done !== 1'b1 && cyc < 2 * n + 40) begin
      start = (cyc == kick_at);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check({nm, "_latency"}, cyc, 2 * n + 2);
    check({nm, "_err"}, err, exp_err);
    repeat (3) @(negedge clk);
    withhold_at = -1;
    check({nm, "_reads"}, rd_cnt - rd0, n);
    check({nm, "_writes"}, wr_cnt - wr0, n + 1);
    check({nm, "_dones"}, done_cnt - dn0, 1);
    check({nm, "_status"}, mem[1023], ref_mem[1023]);
    compare_mem({nm, "_mem"});
  endtask

  initial begin
    int rd0, wr0, dn0;
    logic [31:0] k;
    reset = 1'b1; start = 1'b0; src_addr = 0; dst_addr = 0; len = 0; op = 0; operand = 0;
    fill();
    repeat (2) @(negedge clk);
    check("rst_ctl", {28'h0, busy, done, err, mem_rstrb}, 32'h0);
    check("rst_wmask", mem_wmask, 4'h0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    reset = 1'b0;

    // Directed copy of words 1..4
    for (int i = 0; i < 4; i++) poke((32'h100 >> 2) + i, 32'(i + 1));
    xfer("copy4", 32'h100, 32'h200, 4, 2'b00, 32'h0, -1, -1);
    for (int i = 0; i < 4; i++) check("copy4_word", mem[(32'h200 >> 2) + i], 32'(i + 1));
    check("copy4_magic", mem[1023], 32'hD000_0004);

    poke(32'h100 >> 2, 32'hFFFF_FFFF);
    xfer("addwrap", 32'h100, 32'h300, 1, 2'b01, 32'h1, -1, -1);
    check("addwrap_word", mem[32'h300 >> 2], 32'h0);
    check("addwrap_magic", mem[1023], 32'hD000_0001);

    xfer("len0", 32'h100, 32'h300, 0, 2'b10, 32'h5, -1, -1);
    check("len0_magic", mem[1023], 32'hD000_0000);

    xfer("kick", 32'h140, 32'h240, 8, 2'b10, 32'hA5A5_0F0F, -1, 5);

    // Reset during the WR of the third word: that write commits, nothing after it does
    fill();
    snapshot();
    k = $urandom;
    rd0 = rd_cnt; wr0 = wr_cnt; dn0 = done_cnt;
    drive_start(32'h080, 32'h500, 8, 2'b10, k);
    repeat (5) @(negedge clk);
    check("rst_inwr_wmask", mem_wmask, 4'hF);
    check("rst_inwr_addr", mem_addr, 32'h508);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_ctl", {28'h0, busy, done, err, mem_rstrb}, 32'h0);
    check("rst_mid_wmask", mem_wmask, 4'h0);
    check("rst_mid_addr", mem_addr, 32'h0);
    check("rst_mid_wdata", mem_wdata, 32'h0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    apply_model(32'h080, 32'h500, 3, 2'b10, k);
    check("rst_mid_reads", rd_cnt - rd0, 3);
    check("rst_mid_writes", wr_cnt - wr0, 3);
    check("rst_mid_dones", done_cnt - dn0, 0);
    compare_mem("rst_mid_mem");

    // Withheld read acknowledge
    xfer("rbusy", 32'h100, 32'h600, 6, 2'b01, 32'h10, 2, -1);
    check("rbusy_magic", mem[1023], 32'hD000_0406);
    repeat (2) @(negedge clk);
    check("rbusy_sticky", err, 1'b1);
    xfer("after_err", 32'h180, 32'h680, 3, 2'b00, 32'h0, -1, -1);

    for (int t = 0; t < 25; t++) begin
      int n, wh;
      if (t % 5 == 0) fill();
      n  = $urandom_range(0, 24);
      wh = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n) : -1;
      xfer("rand", 32'($urandom_range(0, 400)) * 4, 32'($urandom_range(0, 400)) * 4, n,
           2'($urandom), $urandom, wh, ($urandom_range(0, 2) == 0) ? $urandom_range(1, 2 * n + 1) : -1);
    end

    check("strobe_excl", both_strobes, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
